axi3_exerciser: RTL

Parametrised successor to the fixed AXI3 tie-off used on unused HBM ports. MODE=0 drives every master output to constant zero, exactly as a tie-off does. MODE=1 turns the block into a self-checking AXI3 burst exerciser: on `start` it writes NUM_BURSTS incrementing-pattern bursts, reads them back, compares every beat and counts errors. It sits directly on one HBM pseudo-channel AXI3 slave port.

---
 rtl/axi3_exerciser.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/axi3_exerciser.sv
// AXI3 master for one HBM pseudo-channel: constant-zero tie-off (MODE=0) or
// self-checking write/read-back burst exerciser (MODE=1).
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for start
// S_AW    | write address valid, waiting for AWREADY
// S_W     | streaming BURST_LEN write beats
// S_B     | waiting for write response
// S_AR    | read address valid, waiting for ARREADY
// S_R     | receiving and checking BURST_LEN read beats
// S_DONE  | one-cycle pass-complete pulse
module axi3_exerciser #(
  parameter int          DW         = 256,
  parameter int          IW         = 6,
  parameter int          AW         = 34,
  parameter int          MODE       = 0,
  parameter logic [63:0] BASE_ADDR  = 64'h0,
  parameter int          BURST_LEN  = 16,
  parameter int          NUM_BURSTS = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [31:0]     error_count,

  output logic [AW-1:0]   m_axi_awaddr,
  output logic [3:0]      m_axi_awlen,
  output logic [2:0]      m_axi_awsize,
  output logic [IW-1:0]   m_axi_awid,
  output logic [1:0]      m_axi_awburst,
  output logic            m_axi_awvalid,
  input  logic            m_axi_awready,

  output logic [DW-1:0]   m_axi_wdata,
  output logic [DW/8-1:0] m_axi_wstrb,
  output logic            m_axi_wvalid,
  output logic            m_axi_wlast,
  input  logic            m_axi_wready,

  input  logic [1:0]      m_axi_bresp,
  input  logic            m_axi_bvalid,
  output logic            m_axi_bready,

  output logic [AW-1:0]   m_axi_araddr,
  output logic            m_axi_arvalid,
  output logic [IW-1:0]   m_axi_arid,
  output logic [3:0]      m_axi_arlen,
  output logic [2:0]      m_axi_arsize,
  output logic [1:0]      m_axi_arburst,
  input  logic            m_axi_arready,

  input  logic [DW-1:0]   m_axi_rdata,
  input  logic            m_axi_rvalid,
  input  logic [1:0]      m_axi_rresp,
  input  logic            m_axi_rlast,
  output logic            m_axi_rready
);

  localparam int            NBYTES     = DW / 8;
  localparam bit            EXER       = (MODE == 1);
  localparam logic [3:0]    LEN        = 4'(BURST_LEN - 1);
  localparam logic [2:0]    SIZE       = 3'($clog2(NBYTES));
  localparam logic [AW-1:0] STRIDE     = AW'(BURST_LEN * NBYTES);
  localparam logic [AW-1:0] BASE       = BASE_ADDR[AW-1:0];
  localparam logic [15:0]   LAST_BURST = 16'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t        state, state_nxt;
  logic          aw_v, w_v, b_r, ar_v, r_r;
  logic          go, last_beat, last_burst, beat_err;
  logic [15:0]   burst_cnt;
  logic [3:0]    beat_cnt;
  logic [31:0]   wr_k, rd_k, err_cnt;
  logic [AW-1:0] addr;

  // Start is only honoured from idle, and never in plug mode.
  assign go         = EXER && start && (state == S_IDLE);
  assign last_beat  = (beat_cnt == LEN);
  assign last_burst = (burst_cnt == LAST_BURST);
  assign beat_err   = (m_axi_rdata != {(DW/32){rd_k}}) || (m_axi_rresp != 2'b00) ||
                      (m_axi_rlast != last_beat);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    aw_v      = 1'b0;
    w_v       = 1'b0;
    b_r       = 1'b0;
    ar_v      = 1'b0;
    r_r       = 1'b0;
    case (state)
      S_IDLE: if (go) state_nxt = S_AW;
      S_AW: begin
        aw_v = 1'b1;
        if (m_axi_awready) state_nxt = S_W;
      end
      S_W: begin
        w_v = 1'b1;
        if (m_axi_wready && last_beat) state_nxt = S_B;
      end
      S_B: begin
        b_r = 1'b1;
        if (m_axi_bvalid) state_nxt = last_burst ? S_AR : S_AW;
      end
      S_AR: begin
        ar_v = 1'b1;
        if (m_axi_arready) state_nxt = S_R;
      end
      S_R: begin
        r_r = 1'b1;
        if (m_axi_rvalid && last_beat) state_nxt = last_burst ? S_DONE : S_AR;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      burst_cnt <= '0;
      beat_cnt  <= '0;
      wr_k      <= '0;
      rd_k      <= '0;
      err_cnt   <= '0;
      addr      <= '0;
    end else begin
      if (go) begin
        burst_cnt <= '0;
        beat_cnt  <= '0;
        wr_k      <= '0;
        rd_k      <= '0;
        err_cnt   <= '0;
        addr      <= BASE;
      end
      if (w_v && m_axi_wready) begin
        wr_k     <= wr_k + 32'd1;
        beat_cnt <= last_beat ? 4'd0 : beat_cnt + 4'd1;
      end
      if (b_r && m_axi_bvalid) begin
        if (m_axi_bresp != 2'b00 && err_cnt != '1) err_cnt <= err_cnt + 32'd1;
        // Read phase replays the same address sequence from the base.
        if (last_burst) begin
          burst_cnt <= '0;
          addr      <= BASE;
        end else begin
          burst_cnt <= burst_cnt + 16'd1;
          addr      <= addr + STRIDE;
        end
      end
      if (r_r && m_axi_rvalid) begin
        rd_k     <= rd_k + 32'd1;
        beat_cnt <= last_beat ? 4'd0 : beat_cnt + 4'd1;
        if (beat_err && err_cnt != '1) err_cnt <= err_cnt + 32'd1;
        if (last_beat) begin
          burst_cnt <= burst_cnt + 16'd1;
          addr      <= addr + STRIDE;
        end
      end
    end
  end

  assign busy        = EXER && (state != S_IDLE) && (state != S_DONE);
  assign done        = EXER && (state == S_DONE);
  assign error_count = err_cnt;

  assign m_axi_awvalid = EXER && aw_v;
  assign m_axi_awaddr  = m_axi_awvalid ? addr : '0;
  assign m_axi_awlen   = m_axi_awvalid ? LEN : '0;
  assign m_axi_awsize  = m_axi_awvalid ? SIZE : '0;
  assign m_axi_awburst = m_axi_awvalid ? 2'b01 : 2'b00;
  assign m_axi_awid    = '0;

  assign m_axi_wvalid  = EXER && w_v;
  assign m_axi_wdata   = m_axi_wvalid ? {(DW/32){wr_k}} : '0;
  assign m_axi_wstrb   = m_axi_wvalid ? '1 : '0;
  assign m_axi_wlast   = m_axi_wvalid && last_beat;

  assign m_axi_bready  = EXER && b_r;

  assign m_axi_arvalid = EXER && ar_v;
  assign m_axi_araddr  = m_axi_arvalid ? addr : '0;
  assign m_axi_arlen   = m_axi_arvalid ? LEN : '0;
  assign m_axi_arsize  = m_axi_arvalid ? SIZE : '0;
  assign m_axi_arburst = m_axi_arvalid ? 2'b01 : 2'b00;
  assign m_axi_arid    = '0;

  assign m_axi_rready  = EXER && r_r;

endmodule
